// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one 16-bit bitwise logic unit among NREQ requesters
// Ports: clk, reset (sync, active-high); req_valid/req_ready per requester with packed
// req_a/req_b (16 bits each) and req_op (2 bits each); resp_valid/resp_ready handshake carrying
// resp_data, resp_id and resp_err; busy is high outside IDLE.
// Build macro LU_XOR_EN: when defined op 11 computes a^b, otherwise op 11 returns 0 with resp_err.
module logic_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [15:0]          resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_err,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last_grant, gnt, idx;
  logic found;
  logic [15:0] a, b, res;
  logic [1:0] op;
  logic err;
  // search starts just after the last grant and wraps at NREQ-1, not at 2^ID_W
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign req_ready = (state == IDLE && !reset && found) ? (NREQ'(1) << gnt) : '0;
  assign busy = state != IDLE;
  always_comb begin
`ifdef LU_XOR_EN
    res = op == 2'b00 ? (a | b) : op == 2'b01 ? (a & b) : op == 2'b10 ? ~a : (a ^ b);
    err = 1'b0;
`else
    res = op == 2'b00 ? (a | b) : op == 2'b01 ? (a & b) : op == 2'b10 ? ~a : 16'h0000;
    err = op == 2'b11;
`endif
  end
  always_comb begin
    state_n = state == IDLE ? (found ? EXEC : IDLE) :
              state == EXEC ? RESP :
              (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_id <= '0;
      resp_err <= 1'b0;
      last_grant <= ID_W'(NREQ - 1);
      a <= '0;
      b <= '0;
      op <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        a <= req_a[16*gnt +: 16];
        b <= req_b[16*gnt +: 16];
        op <= req_op[2*gnt +: 2];
        resp_id <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        resp_data <= res;
        resp_err <= err;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed and randomized check of logic_unit_arbiter against a transaction-level model
module tb_logic_unit_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [7:0] req_op = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic [1:0] resp_id;
  logic resp_err;
  logic busy;
  int n_cmp = 0;
  int n_err = 0;
  int lg = 3;

  logic_unit_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] v);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (last + k) % 4;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00: return {1'b0, a | b};
      2'b01: return {1'b0, a & b};
      2'b10: return {1'b0, ~a};
`ifdef LU_XOR_EN
      default: return {1'b0, a ^ b};
`else
      default: return {1'b1, 16'h0000};
`endif
    endcase
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_op[2*i +: 2] = op;
  endtask

  task automatic txn(input logic [3:0] v, input int hold);
    int g;
    logic [16:0] e;
    req_valid = v;
    resp_ready = 1'b0;
    #1;
    g = rr_pick(lg, v);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    if (g < 0) begin
      chk("no_grant", 32'(req_ready), 32'd0);
      tick();
      chk("no_grant_busy", 32'(busy), 32'd0);
      chk("no_grant_ready", 32'(req_ready), 32'd0);
    end else begin
      chk("grant", 32'(req_ready), 32'd1 << g);
      e = model(req_op[2*g +: 2], req_a[16*g +: 16], req_b[16*g +: 16]);
      tick();
      lg = g;
      chk("exec_ready", 32'(req_ready), 32'd0);
      chk("exec_valid", 32'(resp_valid), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      tick();
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_data", 32'(resp_data), 32'(e[15:0]));
      chk("resp_id", 32'(resp_id), 32'(g));
      chk("resp_err", 32'(resp_err), 32'(e[16]));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", 32'(resp_data), 32'(e[15:0]));
        chk("hold_id", 32'(resp_id), 32'(g));
        chk("hold_ready", 32'(req_ready), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
      end
      resp_ready = 1'b1;
      #1;
      chk("resp_no_accept", 32'(req_ready), 32'd0);
      tick();
      resp_ready = 1'b0;
      chk("resp_done", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'hF;
    set_req(0, 16'hF0F0, 16'h0F0F, 2'b00);
    for (int i = 1; i < 4; i++) set_req(i, 16'h1234, 16'h5678, 2'b01);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_data", 32'(resp_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    lg = 3;
    txn(4'hF, 0);
    for (int i = 0; i < 4; i++) set_req(i, 16'(i), 16'hFFFF, 2'b01);
    for (int n = 0; n < 6; n++) txn(4'hF, 0);
    txn(4'b0011, 5);
    txn(4'b0011, 0);
    set_req(2, 16'hAAAA, 16'h5555, 2'b00);
    req_valid = 4'b0100;
    #1;
    chk("rx_grant", 32'(req_ready), 32'd4);
    tick();
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("rx_ready", 32'(req_ready), 32'd0);
    chk("rx_busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b0;
    lg = 3;
    for (int r = 0; r < 3; r++) begin
      chk("rx_no_resp", 32'(resp_valid), 32'd0);
      chk("rx_idle", 32'(busy), 32'd0);
      tick();
    end
    set_req(0, 16'h00FF, 16'h0F0F, 2'b10);
    txn(4'b0101, 0);
    txn(4'b0101, 0);
    set_req(3, 16'hAAAA, 16'hFFFF, 2'b11);
    txn(4'b1000, 1);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        set_req(i, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (OR/AND/NOT, optional XOR) among NREQ requesters.
- Round-robin arbitration, one outstanding operation, registered result with valid/ready backpressure.
- Sits between client blocks (ALU helpers, test harness, memory-mapped glue) and the shared combinational logic datapath.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of requester ID; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high; handshake when valid&ready.
- req_a  input  NREQ*16  operand A, requester i at bits [16*i+15:16*i].
- req_b  input  NREQ*16  operand B, same packing.
- req_op  input  NREQ*2  opcode, requester i at [2*i+1:2*i]; 00 OR, 01 AND, 10 NOT a, 11 XOR.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  16  result word.
- resp_id  output  ID_W  index of requester that owns resp_data.
- resp_err  output  1  opcode was illegal in this build.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (sampled at clk edge): state=IDLE, resp_valid=0, resp_data=16'h0000, resp_id=0, resp_err=0, last_grant=NREQ-1 (requester 0 has first priority). req_ready forced to 0 while reset is high.
- IDLE: combinational search starting at (last_grant+1) mod NREQ, wrapping, for the first set req_valid bit g. Assert req_ready[g] only; others 0. On the edge: latch req_a/b/op of g, resp_id<=g, last_grant<=g, state->EXEC. No valid requests: stay IDLE, req_ready=0.
- Requesters may drop req_valid before handshake; arbitration re-evaluated every IDLE cycle, so no grant is held over.
- EXEC: resp_data<=f(op,a,b), resp_err per opcode, resp_valid<=1, state->RESP. req_ready=0.
- RESP: resp_valid=1; resp_data, resp_id, resp_err held stable. resp_ready=1 on edge: resp_valid<=0, state->IDLE. No requests are accepted in RESP even if resp_ready is high that cycle.
- Latency: handshake edge E0 -> resp_valid high after E0+1 edge (2 edges). Peak throughput one op per 3 cycles with resp_ready held high.
- Arithmetic: pure bitwise, 16-bit, no carries. NOT ignores b.
- Reset mid-operation (EXEC or RESP): transaction silently dropped, no response, priority restarts at requester 0.
- NREQ not a power of two: pointer wraps at NREQ-1 -> 0, never at 2^ID_W.

Optional Feature:
- Macro LU_XOR_EN.
- Defined: op 11 gives a^b, resp_err=0.
- Undefined: op 11 still accepted and arbitrated normally; resp_data=16'h0000, resp_err=1. No XOR logic synthesized.

Test Plan:
- Reset: hold reset 3 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, resp_data=0000, busy=0; first grant after release goes to req 0.
- Single OR: req0 valid, a=F0F0, b=0F0F, op=00 -> req_ready[0] same cycle; 2 edges later resp_valid=1, resp_data=FFFF, resp_id=0, resp_err=0.
- Fairness: all four req_valid held high, resp_ready=1, ops AND with a=i, b=FFFF -> grant order 0,1,2,3,0,1; resp_data equals requester index each time.
- Backpressure: resp_ready=0 for 5 cycles in RESP with req1 pending -> resp_data/resp_id stable, req_ready all 0, busy=1; release -> req1 granted the following IDLE cycle.
- Reset in EXEC: grant req2, assert reset next cycle -> resp_valid never rises; afterwards req2 and req0 both valid -> req0 granted first.
- Op 11, a=AAAA, b=FFFF: with LU_XOR_EN -> 5555, err 0; without -> 0000, err 1.
